// File: rtl/um245r_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : um245r_bridge_pkg
// Description : Shared types for the UM245R-style CPU FIFO bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package um245r_bridge_pkg;

   // CPU read-strobe state machine
   typedef enum logic [0:0] {
      RD_IDLE  = 1'b0,
      RD_DRIVE = 1'b1
   } rd_state_t;

endpackage : um245r_bridge_pkg
`default_nettype wire

// File: rtl/um245r_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, power-of-two depth, occupancy count and
//               first-word-fall-through head. Push is ignored while full and
//               pop is ignored while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointer and occupancy update; pointers wrap naturally at power-of-two depth
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/um245r_bridge.sv
`default_nettype none
// ============================================================================
// Module      : um245r_bridge
// Description : UM245R-style CPU parallel FIFO port. CPU side uses _rd / wr /
//               _rxf / _txe on a split data bus; host side uses valid/ready
//               byte streams. Independent RX and TX FIFOs.
//               Optional feature macro: UM245R_BRIDGE_LOOPBACK_EN (adds the
//               loopback input that routes TX FIFO output into the RX FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
module um245r_bridge
   import um245r_bridge_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int RX_DEPTH = 16,
   parameter int TX_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [WIDTH-1:0]            d_in,
   output logic [WIDTH-1:0]            d_out,
   output logic                        d_oe,
   input  logic                        _rd,
   input  logic                        wr,
   output logic                        _rxf,
   output logic                        _txe,
   input  logic [WIDTH-1:0]            rx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   output logic [WIDTH-1:0]            tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   output logic [$clog2(RX_DEPTH):0]   rx_count,
   output logic [$clog2(TX_DEPTH):0]   tx_count,
   output logic                        rd_err,
`ifdef UM245R_BRIDGE_LOOPBACK_EN
   output logic                        wr_err,
   input  logic                        loopback
`else
   output logic                        wr_err
`endif
);

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   rd_state_t        state_q, state_d;
   logic             rd_q, rd_d, rd_prev_q, rd_prev_d, rd_armed_q, rd_armed_d;
   logic             wr_q, wr_d, wr_prev_q, wr_prev_d, wr_armed_q, wr_armed_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             wpush_q, wpush_d;
   logic             rd_err_q, rd_err_d;
   logic             wr_err_q, wr_err_d;

   logic             rd_fall, rd_rise, wr_fall;
   logic             rx_pop_cpu;
   logic             lb_en, lb_move;

   logic             rx_push, rx_pop, rx_full, rx_empty;
   logic [WIDTH-1:0] rx_head, rx_din;
   logic             tx_push, tx_pop, tx_full, tx_empty;
   logic [WIDTH-1:0] tx_head;

`ifdef UM245R_BRIDGE_LOOPBACK_EN
   assign lb_en = loopback;
`else
   assign lb_en = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Strobe edge detection. A strobe only becomes "armed" once it has been
   // seen high since reset, so a strobe held low through reset release
   // cannot fake a falling edge.
   // ------------------------------------------------------------------
   assign rd_fall = rd_armed_q & rd_prev_q & ~rd_q;
   assign rd_rise = ~rd_prev_q & rd_q;
   assign wr_fall = wr_armed_q & wr_prev_q & ~wr_q;

   // Next-state for strobe samplers and the write path
   always_comb begin
      rd_d       = _rd;
      rd_prev_d  = rd_q;
      rd_armed_d = rd_armed_q | _rd;
      wr_d       = wr;
      wr_prev_d  = wr_q;
      wr_armed_d = wr_armed_q | wr;
      // capture bus data on the edge that samples wr going low
      wdata_d    = (wr_q && !wr) ? d_in : wdata_q;
      wpush_d    = wr_fall;
      wr_err_d   = wpush_q & tx_full;
   end

   // Read FSM next-state and hold-register logic
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      rd_err_d     = 1'b0;
      rx_pop_cpu   = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (rd_fall) begin
               state_d      = RD_DRIVE;
               hold_valid_d = ~rx_empty;
               hold_d       = rx_empty ? '0 : rx_head;
               rd_err_d     = rx_empty;
            end
         end
         RD_DRIVE: begin
            if (rd_rise) begin
               state_d    = RD_IDLE;
               rx_pop_cpu = hold_valid_q;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // All bridge state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RD_IDLE;
         rd_q         <= 1'b1;
         rd_prev_q    <= 1'b1;
         rd_armed_q   <= 1'b0;
         wr_q         <= 1'b1;
         wr_prev_q    <= 1'b1;
         wr_armed_q   <= 1'b0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         wdata_q      <= '0;
         wpush_q      <= 1'b0;
         rd_err_q     <= 1'b0;
         wr_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_q         <= rd_d;
         rd_prev_q    <= rd_prev_d;
         rd_armed_q   <= rd_armed_d;
         wr_q         <= wr_d;
         wr_prev_q    <= wr_prev_d;
         wr_armed_q   <= wr_armed_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         wdata_q      <= wdata_d;
         wpush_q      <= wpush_d;
         rd_err_q     <= rd_err_d;
         wr_err_q     <= wr_err_d;
      end
   end

   // ------------------------------------------------------------------
   // FIFO steering: host streams, or TX->RX loopback when enabled
   // ------------------------------------------------------------------
   assign lb_move  = lb_en & ~tx_empty & ~rx_full;
   assign rx_ready = ~rx_full & ~lb_en;
   assign tx_valid = ~tx_empty & ~lb_en;
   assign tx_data  = tx_head;

   assign rx_push  = lb_en ? lb_move : (rx_valid & rx_ready);
   assign rx_din   = lb_en ? tx_head : rx_data;
   assign rx_pop   = rx_pop_cpu;
   assign tx_push  = wpush_q & ~tx_full;
   assign tx_pop   = lb_en ? lb_move : (tx_valid & tx_ready);

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .din   (rx_din),
      .pop   (rx_pop),
      .head  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push),
      .din   (wdata_q),
      .pop   (tx_pop),
      .head  (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   // ------------------------------------------------------------------
   // CPU-side outputs
   // ------------------------------------------------------------------
   assign d_oe   = (state_q == RD_DRIVE);
   assign d_out  = d_oe ? hold_q : '0;
   assign _rxf   = rx_empty | (state_q != RD_IDLE);
   assign _txe   = tx_full;
   assign rd_err = rd_err_q;
   assign wr_err = wr_err_q;

endmodule : um245r_bridge
`default_nettype wire

// File: tb/tb_um245r_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_um245r_bridge
// Description : Directed self-checking bench for um245r_bridge with
//               scoreboard queues for the RX (CPU read) and TX (host) paths.
//               Loopback section is built when UM245R_BRIDGE_LOOPBACK_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_um245r_bridge;

   localparam int WIDTH    = 8;
   localparam int RX_DEPTH = 16;
   localparam int TX_DEPTH = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] d_out;
   logic             d_oe;
   logic             _rd, wr;
   logic             _rxf, _txe;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid, rx_ready;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid, tx_ready;
   logic [4:0]       rx_count, tx_count;
   logic             rd_err, wr_err;
`ifdef UM245R_BRIDGE_LOOPBACK_EN
   logic             loopback = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int rd_err_seen = 0;
   int wr_err_seen = 0;
   int tx_valid_seen = 0;

   logic [WIDTH-1:0] rx_sb[$];
   logic [WIDTH-1:0] tx_sb[$];

   um245r_bridge #(.WIDTH(WIDTH), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .d_in     (d_in),
      .d_out    (d_out),
      .d_oe     (d_oe),
      ._rd      (_rd),
      .wr       (wr),
      ._rxf     (_rxf),
      ._txe     (_txe),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_count (rx_count),
      .tx_count (tx_count),
      .rd_err   (rd_err),
`ifdef UM245R_BRIDGE_LOOPBACK_EN
      .wr_err   (wr_err),
      .loopback (loopback)
`else
      .wr_err   (wr_err)
`endif
   );

   always #5 clk = ~clk;

   // pulse monitors, sampled away from the active edge
   always @(negedge clk) begin
      if (rd_err === 1'b1) rd_err_seen <= rd_err_seen + 1;
      if (wr_err === 1'b1) wr_err_seen <= wr_err_seen + 1;
      if (tx_valid === 1'b1) tx_valid_seen <= tx_valid_seen + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rx_push(input logic [WIDTH-1:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      rx_sb.push_back(b);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // full CPU read strobe; compares the held word against the scoreboard
   task automatic cpu_read(input string tag, input int n_low, input int n_high);
      logic [WIDTH-1:0] exp;
      exp = (rx_sb.size() > 0) ? rx_sb.pop_front() : '0;
      _rd = 1'b0;
      idle(n_low);
      chk({tag, "_oe"}, {31'd0, d_oe}, 32'd1);
      chk({tag, "_data"}, {24'd0, d_out}, {24'd0, exp});
      _rd = 1'b1;
      idle(n_high);
   endtask

   task automatic cpu_write(input logic [WIDTH-1:0] b);
      d_in = b;
      wr   = 1'b0;
      idle(2);
      wr   = 1'b1;
      idle(2);
   endtask

   initial begin
      int base;
      reset = 1'b1; _rd = 1'b1; wr = 1'b1; d_in = '0;
      rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
      idle(3);

      // ---- reset state ----
      chk("rst_d_oe",     {31'd0, d_oe},     32'd0);
      chk("rst_d_out",    {24'd0, d_out},    32'd0);
      chk("rst_rxf",      {31'd0, _rxf},     32'd1);
      chk("rst_txe",      {31'd0, _txe},     32'd0);
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_rx_count", {27'd0, rx_count}, 32'd0);
      chk("rst_tx_count", {27'd0, tx_count}, 32'd0);
      reset = 1'b0;
      idle(4);

      // ---- push a,b,c then read them back ----
      rx_push(8'h61); rx_push(8'h62); rx_push(8'h63);
      chk("abc_rxf",   {31'd0, _rxf},     32'd0);
      chk("abc_count", {27'd0, rx_count}, 32'd3);
      cpu_read("rd_a", 20, 10);
      cpu_read("rd_b", 20, 10);
      cpu_read("rd_c", 20, 10);
      chk("abc_rxf_after", {31'd0, _rxf},     32'd1);
      chk("abc_count_end", {27'd0, rx_count}, 32'd0);

      // ---- hold stability: new data arrives mid-strobe ----
      rx_push(8'h63);
      _rd = 1'b0;
      idle(5);
      rx_push(8'h64);
      idle(10);
      chk("hold_oe",   {31'd0, d_oe},   32'd1);
      chk("hold_data", {24'd0, d_out},  {24'd0, rx_sb.pop_front()});
      _rd = 1'b1;
      idle(10);
      cpu_read("rd_d", 20, 10);

      // ---- read while empty ----
      base = rd_err_seen;
      chk("empty_rxf", {31'd0, _rxf}, 32'd1);
      cpu_read("rd_empty", 20, 10);
      chk("empty_err_pulses", base < 0 ? 32'hFFFF : rd_err_seen - base, 32'd1);
      chk("empty_count", {27'd0, rx_count}, 32'd0);

      // ---- TX fill to full, overflow, drain ----
      base = wr_err_seen;
      for (int i = 0; i < 16; i++) begin
         cpu_write(i[7:0]);
         tx_sb.push_back(i[7:0]);
      end
      idle(3);
      chk("fill_txe",      {31'd0, _txe},     32'd1);
      chk("fill_count",    {27'd0, tx_count}, 32'd16);
      chk("fill_no_err",   wr_err_seen - base, 32'd0);
      cpu_write(8'd16);
      idle(3);
      chk("ovf_err_pulses", wr_err_seen - base, 32'd1);
      chk("ovf_count",      {27'd0, tx_count}, 32'd16);
      tx_ready = 1'b1;
      for (int k = 0; k < 60 && tx_sb.size() > 0; k++) begin
         if (tx_valid === 1'b1) chk("drain_data", {24'd0, tx_data}, {24'd0, tx_sb.pop_front()});
         @(negedge clk);
      end
      chk("drain_timeout",  tx_sb.size(), 32'd0);
      idle(1);
      chk("drain_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("drain_count",    {27'd0, tx_count}, 32'd0);
      tx_ready = 1'b0;

      // ---- reset while driving the bus ----
      cpu_write(8'hAA);
      rx_push(8'h65);
      _rd = 1'b0;
      idle(5);
      chk("pre_rst_oe", {31'd0, d_oe}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_oe",    {31'd0, d_oe},     32'd0);
      chk("async_rst_rxcnt", {27'd0, rx_count}, 32'd0);
      chk("async_rst_txcnt", {27'd0, tx_count}, 32'd0);
      rx_sb.delete();
      idle(2);
      reset = 1'b0;
      base = rd_err_seen;
      idle(10);
      chk("held_low_no_read", {31'd0, d_oe}, 32'd0);
      chk("held_low_no_err",  rd_err_seen - base, 32'd0);
      _rd = 1'b1;
      idle(4);

`ifdef UM245R_BRIDGE_LOOPBACK_EN
      // ---- loopback: CPU write returns on CPU read ----
      loopback = 1'b1;
      base = tx_valid_seen;
      cpu_write(8'h5A);
      rx_sb.push_back(8'h5A);
      idle(4);
      cpu_read("lb_rd", 20, 10);
      chk("lb_tx_valid_never", tx_valid_seen - base, 32'd0);
      loopback = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule : tb_um245r_bridge
`default_nettype wire
